multicycle_controller: RTL and testbench

Control unit for the multi-cycle RV32I core. It sequences the shared datapath (single ALU, unified memory port, immediate extender, register file) through a Moore state machine. It decodes the opcode into the 2-bit immediate-select code consumed by the immediate extender, and stalls on a memory ready handshake. It sits between the instruction register and every datapath mux and enable.

---
 rtl/riscv_ctrl_pkg.sv | 67 ++++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared types and encodings for the multi-cycle RV32I
//                control unit: FSM states, opcodes, mux-select and ALU codes.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Immediate extender select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Coarse ALU operation from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps the FSM's coarse ALU operation plus instruction funct
//                fields to the 3-bit ALU control code. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic       Op5,
    input  logic       Funct7b5,
    output logic [2:0] ALUControl
);

    // Decode ALU control; only R-type (Op5=1) can select subtract via funct7
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct3)
                    3'b000:  ALUControl = (Op5 & Funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore-style control FSM for the multi-cycle RV32I core.
//                Sequences the shared datapath, decodes ImmSrc from the
//                opcode and stalls on the memory ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       Illegal
);

    state_t     state_q;
    state_t     state_d;
    state_t     w_state;
    logic [1:0] w_alu_op;

    // While reset is asserted, present FETCH outputs regardless of the
    // current state so an interrupted instruction cannot leak an enable.
    assign w_state = rst ? S_FETCH : state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate format depends only on the opcode in the instruction register
    always_comb begin
        case (Op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    // Next-state and datapath control outputs
    always_comb begin
        state_d   = w_state;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        w_alu_op  = ALUOP_ADD;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        MemReq    = 1'b0;
        Illegal   = 1'b0;

        case (w_state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Target PC (OldPC + imm) is formed here for branch/jal
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        state_d = S_FETCH;
                        Illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemReq   = 1'b1;
                MemWrite = MemReady;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_RD2;
                w_alu_op = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // Link value PC+4 comes from OldPC + 4; target was latched in DECODE
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_RD2;
                w_alu_op = ALUOP_SUB;
                case (Funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: PCWrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemReq   = 1'b0;
            Illegal  = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .Funct3     (Funct3),
        .Op5        (Op[5]),
        .Funct7b5   (Funct7b5),
        .ALUControl (ALUControl)
    );

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller.
//                Output bundle per cycle is compared to hand-computed vectors
//                {ImmSrc,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,ALUControl,
//                 IRWrite,PCWrite,RegWrite,MemWrite,MemReq,Illegal}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       MemReady;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemReq;
    logic       Illegal;

    int n_vec;
    int n_err;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct3     (Funct3),
        .Funct7b5   (Funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemReq     (MemReq),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [17:0] w_obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                         IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Illegal};

    // Build an expected output vector from hand-chosen field values
    function automatic logic [17:0] pk(
        input logic [1:0] imm, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] res, input logic adr, input logic [2:0] alu,
        input logic ir, input logic pc, input logic rw, input logic mw,
        input logic mr, input logic ill);
        return {imm, a, b, res, adr, alu, ir, pc, rw, mw, mr, ill};
    endfunction

    task automatic check_vec(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        Op       = 7'b0000011;
        Funct3   = 3'b010;
        Funct7b5 = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b1;

        // Reset: FETCH values with every enable forced low
        repeat (3) cyc();
        check_vec("reset", w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 0,0,0,0,0,0));
        rst = 1'b0;
        #1;

        // lw, MemReady tied high: 5 cycles
        check_vec("lw_fetch",   w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); check_vec("lw_decode",  w_obs, pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("lw_memadr",  w_obs, pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("lw_memread", w_obs, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 0,0,0,0,1,0));
        cyc(); check_vec("lw_memwb",   w_obs, pk(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 0,0,1,0,0,0));
        cyc();

        // sw with two wait cycles in MEMWRITE
        Op = 7'b0100011; #1;
        check_vec("sw_fetch",   w_obs, pk(2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); check_vec("sw_decode",  w_obs, pk(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("sw_memadr",  w_obs, pk(2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); MemReady = 1'b0; #1;
        check_vec("sw_wait1",   w_obs, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 0,0,0,0,1,0));
        cyc(); check_vec("sw_wait2",   w_obs, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 0,0,0,0,1,0));
        cyc(); MemReady = 1'b1; #1;
        check_vec("sw_write",   w_obs, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 0,0,0,1,1,0));
        cyc();

        // R-type sub
        Op = 7'b0110011; Funct3 = 3'b000; Funct7b5 = 1'b1; #1;
        check_vec("r_fetch",    w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); cyc();
        check_vec("r_exec_sub", w_obs, pk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 0,0,0,0,0,0));
        cyc(); check_vec("r_aluwb",    w_obs, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 0,0,1,0,0,0));
        cyc();

        // I-type with same funct fields: addi, never sub
        Op = 7'b0010011; #1;
        cyc(); cyc();
        check_vec("i_exec_add", w_obs, pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("i_aluwb",    w_obs, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 0,0,1,0,0,0));
        cyc();

        // R-type and/or/slt decodes
        Op = 7'b0110011; Funct3 = 3'b111; Funct7b5 = 1'b0; #1;
        cyc(); cyc();
        check_vec("r_exec_and", w_obs, pk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b010, 0,0,0,0,0,0));
        cyc(); cyc();
        Op = 7'b0010011; Funct3 = 3'b010; #1;
        cyc(); cyc();
        check_vec("i_exec_slt", w_obs, pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b101, 0,0,0,0,0,0));
        cyc(); cyc();
        Op = 7'b0010011; Funct3 = 3'b110; #1;
        cyc(); cyc();
        check_vec("i_exec_or",  w_obs, pk(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b011, 0,0,0,0,0,0));
        cyc(); cyc();

        // bne taken (Zero=0), 3 cycles
        Op = 7'b1100011; Funct3 = 3'b001; Zero = 1'b0; #1;
        check_vec("bne_fetch",  w_obs, pk(2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); check_vec("bne_decode", w_obs, pk(2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("bne_taken",  w_obs, pk(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 0,1,0,0,0,0));
        Zero = 1'b1; #1;
        check_vec("bne_not",    w_obs, pk(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 0,0,0,0,0,0));
        cyc(); check_vec("bne_refetch", w_obs, pk(2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));

        // beq taken, then unsupported branch funct3 never writes PC
        Funct3 = 3'b000; Zero = 1'b1; #1;
        cyc(); cyc();
        check_vec("beq_taken",  w_obs, pk(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 0,1,0,0,0,0));
        cyc();
        Funct3 = 3'b100; #1;
        cyc(); cyc();
        check_vec("blt_nowr",   w_obs, pk(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 0,0,0,0,0,0));
        cyc();

        // jal: JAL then ALUWB
        Op = 7'b1101111; Funct3 = 3'b000; #1;
        check_vec("jal_fetch",  w_obs, pk(2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); cyc();
        check_vec("jal_jal",    w_obs, pk(2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 0,1,0,0,0,0));
        cyc(); check_vec("jal_aluwb",  w_obs, pk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 0,0,1,0,0,0));
        cyc();

        // lui is unsupported: Illegal pulse in DECODE, 2 cycles
        Op = 7'b0110111; #1;
        cyc(); check_vec("ill_decode", w_obs, pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,1));
        cyc(); check_vec("ill_fetch",  w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));

        // FETCH stall holds in FETCH with only MemReq asserted
        Op = 7'b0000011; MemReady = 1'b0; #1;
        check_vec("fetch_wait1", w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 0,0,0,0,1,0));
        cyc(); check_vec("fetch_wait2", w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 0,0,0,0,1,0));
        MemReady = 1'b1; #1;

        // lw aborted by reset in MEMREAD
        cyc(); cyc(); cyc();
        MemReady = 1'b0; #1;
        check_vec("abort_memread", w_obs, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 0,0,0,0,1,0));
        rst = 1'b1; MemReady = 1'b1; #1;
        check_vec("abort_rstcyc",  w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 0,0,0,0,0,0));
        cyc(); check_vec("abort_rst2",    w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 0,0,0,0,0,0));
        rst = 1'b0; #1;
        check_vec("abort_fetch",   w_obs, pk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1,1,0,0,1,0));
        cyc(); check_vec("abort_decode",  w_obs, pk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
